// File: rtl/bridge_cmd_store_if.sv
// Command-store bus for the UART bridge master: command FIFO push/pop/head
// signals plus the local byte-wide memory port.
interface bridge_cmd_store_if #(
    parameter int DATA_WIDTH      = 8,
    parameter int BB_ADDR_WIDTH   = 12,
    parameter int BUS_ADDR_WIDTH  = 16,
    parameter int LMEM_ADDR_WIDTH = 11
) ();
    localparam int CW = DATA_WIDTH + BB_ADDR_WIDTH + 1;

    logic                       enq;
    logic [CW-1:0]              enq_data;
    logic                       deq;
    logic                       cmd_valid;
    logic                       full;
    logic                       cmd_mode;
    logic [DATA_WIDTH-1:0]      cmd_wdata;
    logic [BUS_ADDR_WIDTH-1:0]  cmd_bus_addr;

    logic                       lmem_wen;
    logic                       lmem_ren;
    logic [LMEM_ADDR_WIDTH-1:0] lmem_addr;
    logic [DATA_WIDTH-1:0]      lmem_wdata;
    logic [DATA_WIDTH-1:0]      lmem_rdata;
    logic                       lmem_rvalid;

    modport slave (
        input  enq, enq_data, deq, lmem_wen, lmem_ren, lmem_addr, lmem_wdata,
        output cmd_valid, full, cmd_mode, cmd_wdata, cmd_bus_addr,
               lmem_rdata, lmem_rvalid
    );

    modport master (
        output enq, enq_data, deq, lmem_wen, lmem_ren, lmem_addr, lmem_wdata,
        input  cmd_valid, full, cmd_mode, cmd_wdata, cmd_bus_addr,
               lmem_rdata, lmem_rvalid
    );
endinterface

// File: rtl/bridge_cmd_store.sv
// Command FIFO with bridge-to-bus address expansion and local BRAM for the
// UART bridge master. Define BRIDGE_OVF_CNT_EN to add the ovf_count port.
module bridge_cmd_store #(
    parameter int DATA_WIDTH         = 8,
    parameter int BB_ADDR_WIDTH      = 12,
    parameter int BUS_ADDR_WIDTH     = 16,
    parameter int BUS_MEM_ADDR_WIDTH = 12,
    parameter int FIFO_DEPTH         = 8,
    parameter int LMEM_SIZE          = 2048
) (
    input  logic                clk,
    input  logic                rst,
`ifdef BRIDGE_OVF_CNT_EN
    output logic [7:0]          ovf_count,
`endif
    bridge_cmd_store_if.slave   bus
);
    localparam int CW              = DATA_WIDTH + BB_ADDR_WIDTH + 1;
    localparam int PTR_W           = $clog2(FIFO_DEPTH);
    localparam int LMEM_ADDR_WIDTH = $clog2(LMEM_SIZE);
    localparam int OFF_W           = BB_ADDR_WIDTH - 2;

    logic [CW-1:0]  fifo_mem [FIFO_DEPTH];
    logic [PTR_W:0] wr_ptr;
    logic [PTR_W:0] rd_ptr;
    logic           empty;
    logic           is_full;
    logic           do_push;
    logic           do_pop;
    logic [CW-1:0]  head;

    logic [BB_ADDR_WIDTH-1:0]  head_bb;
    logic [1:0]                head_sel;
    logic [OFF_W-1:0]          head_off;
    logic [BUS_ADDR_WIDTH-1:0] bus_addr;

    logic [DATA_WIDTH-1:0] lmem [LMEM_SIZE];
    logic [DATA_WIDTH-1:0] rdata;
    logic                  rvalid;

    // Extra pointer MSB distinguishes full from empty when indices match.
    assign empty   = (wr_ptr == rd_ptr);
    assign is_full = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                     (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);
    assign do_push = bus.enq && (!is_full || bus.deq);
    assign do_pop  = bus.deq && !empty;

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !rst) fifo_mem[wr_ptr[PTR_W-1:0]] <= bus.enq_data;
    end

    // Head fields are forced to zero while the queue is empty.
    always_comb begin
        head = '0;
        if (!empty) head = fifo_mem[rd_ptr[PTR_W-1:0]];
    end

    assign head_bb  = head[BB_ADDR_WIDTH-1:0];
    assign head_sel = head_bb[BB_ADDR_WIDTH-1:BB_ADDR_WIDTH-2];
    assign head_off = head_bb[OFF_W-1:0];

    always_comb begin
        bus_addr = '0;
        bus_addr[BUS_MEM_ADDR_WIDTH +: 2]     = head_sel;
        bus_addr[BUS_MEM_ADDR_WIDTH-1:0]      = BUS_MEM_ADDR_WIDTH'(head_off);
    end

    assign bus.cmd_valid    = !empty;
    assign bus.full         = is_full;
    assign bus.cmd_mode     = head[CW-1];
    assign bus.cmd_wdata    = head[CW-2:BB_ADDR_WIDTH];
    assign bus.cmd_bus_addr = bus_addr;

    // Memory array has no reset so it maps onto block RAM.
    always_ff @(posedge clk) begin
        if (bus.lmem_wen) lmem[bus.lmem_addr] <= bus.lmem_wdata;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rdata  <= '0;
            rvalid <= 1'b0;
        end else begin
            rvalid <= bus.lmem_ren;
            if (bus.lmem_ren) rdata <= lmem[bus.lmem_addr];
        end
    end

    assign bus.lmem_rdata  = rdata;
    assign bus.lmem_rvalid = rvalid;

`ifdef BRIDGE_OVF_CNT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            ovf_count <= '0;
        end else if (bus.enq && is_full && !bus.deq && (ovf_count != 8'hFF)) begin
            ovf_count <= ovf_count + 8'd1;
        end
    end
`endif
endmodule

// File: tb/tb_bridge_cmd_store.sv
// Directed self-checking bench for bridge_cmd_store; covers the overflow
// counter when compiled with BRIDGE_OVF_CNT_EN.
module tb_bridge_cmd_store;
    logic clk;
    logic rst;
    int   total;
    int   bad;
`ifdef BRIDGE_OVF_CNT_EN
    logic [7:0] ovf_count;
`endif

    bridge_cmd_store_if #(
        .DATA_WIDTH(8), .BB_ADDR_WIDTH(12), .BUS_ADDR_WIDTH(16), .LMEM_ADDR_WIDTH(11)
    ) bus_if ();

    bridge_cmd_store dut (
        .clk       (clk),
        .rst       (rst),
`ifdef BRIDGE_OVF_CNT_EN
        .ovf_count (ovf_count),
`endif
        .bus       (bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_output(input string tag, input logic [15:0] observed,
                                input logic [15:0] expected);
        total++;
        assert (observed === expected) else begin
            bad++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic push(input logic mode, input logic [7:0] data, input logic [11:0] bb);
        bus_if.enq      = 1'b1;
        bus_if.enq_data = {mode, data, bb};
        tick();
        bus_if.enq      = 1'b0;
    endtask

    task automatic pop();
        bus_if.deq = 1'b1;
        tick();
        bus_if.deq = 1'b0;
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst   = 1'b1;
        bus_if.enq        = 1'b0;
        bus_if.enq_data   = '0;
        bus_if.deq        = 1'b0;
        bus_if.lmem_wen   = 1'b0;
        bus_if.lmem_ren   = 1'b0;
        bus_if.lmem_addr  = '0;
        bus_if.lmem_wdata = '0;
        tick();
        tick();
        rst = 1'b0;

        check_output("rst_valid",  16'(bus_if.cmd_valid),   16'h0);
        check_output("rst_full",   16'(bus_if.full),        16'h0);
        check_output("rst_addr",   bus_if.cmd_bus_addr,     16'h0);
        check_output("rst_wdata",  16'(bus_if.cmd_wdata),   16'h0);
        check_output("rst_rdata",  16'(bus_if.lmem_rdata),  16'h0);
        check_output("rst_rvalid", 16'(bus_if.lmem_rvalid), 16'h0);
`ifdef BRIDGE_OVF_CNT_EN
        check_output("rst_ovf",    16'(ovf_count),          16'h0);
`endif

        // Write command, bb 0x123: sel 0, offset 0x123.
        push(1'b1, 8'hAB, 12'h123);
        check_output("w_valid", 16'(bus_if.cmd_valid), 16'h1);
        check_output("w_mode",  16'(bus_if.cmd_mode),  16'h1);
        check_output("w_wdata", 16'(bus_if.cmd_wdata), 16'h00AB);
        check_output("w_addr",  bus_if.cmd_bus_addr,   16'h0123);
        pop();
        check_output("w_popped", 16'(bus_if.cmd_valid), 16'h0);

        pop();
        check_output("deq_empty", 16'(bus_if.cmd_valid), 16'h0);

        push(1'b0, 8'h00, 12'hC05);
        check_output("r_mode", 16'(bus_if.cmd_mode), 16'h0);
        check_output("r_addr", bus_if.cmd_bus_addr,  16'h3005);
        pop();

        // Nine pushes: the ninth must be dropped.
        for (int i = 0; i < 9; i++) begin
            push(1'b1, 8'(i), 12'h400 + 12'(i));
            if (i == 6) check_output("not_full7", 16'(bus_if.full), 16'h0);
            if (i == 7) check_output("full8",     16'(bus_if.full), 16'h1);
        end
        check_output("full9", 16'(bus_if.full), 16'h1);
`ifdef BRIDGE_OVF_CNT_EN
        push(1'b1, 8'hEE, 12'h0);
        push(1'b1, 8'hEE, 12'h0);
        check_output("ovf3", 16'(ovf_count), 16'h3);
`endif
        for (int i = 0; i < 8; i++) begin
            check_output($sformatf("pop%0d_data", i), 16'(bus_if.cmd_wdata), 16'(i));
            check_output($sformatf("pop%0d_addr", i), bus_if.cmd_bus_addr, 16'h1000 + 16'(i));
            pop();
        end
        check_output("drained", 16'(bus_if.cmd_valid), 16'h0);

        // Simultaneous push/pop on a full queue keeps it full and advances head.
        for (int i = 0; i < 8; i++) push(1'b0, 8'h10 + 8'(i), 12'h0);
        bus_if.enq      = 1'b1;
        bus_if.deq      = 1'b1;
        bus_if.enq_data = {1'b1, 8'h99, 12'h800};
        tick();
        bus_if.enq = 1'b0;
        bus_if.deq = 1'b0;
        check_output("ed_full", 16'(bus_if.full),      16'h1);
        check_output("ed_head", 16'(bus_if.cmd_wdata), 16'h0011);
`ifdef BRIDGE_OVF_CNT_EN
        check_output("ed_noovf", 16'(ovf_count), 16'h3);
`endif
        for (int i = 0; i < 7; i++) pop();
        check_output("ed_tail_data", 16'(bus_if.cmd_wdata), 16'h0099);
        check_output("ed_tail_addr", bus_if.cmd_bus_addr,   16'h2000);
        pop();
        check_output("ed_empty", 16'(bus_if.cmd_valid), 16'h0);

        // Push+pop on an empty queue only pushes.
        bus_if.enq      = 1'b1;
        bus_if.deq      = 1'b1;
        bus_if.enq_data = {1'b0, 8'h55, 12'h001};
        tick();
        bus_if.enq = 1'b0;
        bus_if.deq = 1'b0;
        check_output("ee_valid", 16'(bus_if.cmd_valid), 16'h1);
        check_output("ee_data",  16'(bus_if.cmd_wdata), 16'h0055);
        pop();

        // Local memory write then read at the top address.
        bus_if.lmem_wen   = 1'b1;
        bus_if.lmem_addr  = 11'h7FF;
        bus_if.lmem_wdata = 8'h5A;
        tick();
        bus_if.lmem_wen = 1'b0;
        check_output("wr_norvalid", 16'(bus_if.lmem_rvalid), 16'h0);
        bus_if.lmem_ren = 1'b1;
        tick();
        bus_if.lmem_ren = 1'b0;
        check_output("rd_data",   16'(bus_if.lmem_rdata),  16'h005A);
        check_output("rd_rvalid", 16'(bus_if.lmem_rvalid), 16'h1);
        tick();
        check_output("rd_pulse", 16'(bus_if.lmem_rvalid), 16'h0);
        check_output("rd_hold",  16'(bus_if.lmem_rdata),  16'h005A);

        // Same-cycle write and read returns the old byte.
        bus_if.lmem_wen   = 1'b1;
        bus_if.lmem_ren   = 1'b1;
        bus_if.lmem_wdata = 8'hC3;
        tick();
        bus_if.lmem_wen = 1'b0;
        check_output("rf_old", 16'(bus_if.lmem_rdata), 16'h005A);
        tick();
        bus_if.lmem_ren = 1'b0;
        check_output("rf_new", 16'(bus_if.lmem_rdata), 16'h00C3);

        // Reset during a read discards it; memory survives.
        bus_if.lmem_ren = 1'b1;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        bus_if.lmem_ren = 1'b0;
        check_output("rr_rvalid", 16'(bus_if.lmem_rvalid), 16'h0);
        check_output("rr_rdata",  16'(bus_if.lmem_rdata),  16'h0);
`ifdef BRIDGE_OVF_CNT_EN
        check_output("rr_ovf",    16'(ovf_count),          16'h0);
`endif
        bus_if.lmem_ren = 1'b1;
        tick();
        bus_if.lmem_ren = 1'b0;
        check_output("rr_keep", 16'(bus_if.lmem_rdata), 16'h00C3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
